// File: rtl/nor_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : nor_share_arbiter
// Purpose : Round-robin sharing of one registered WIDTH-bit NOR unit among
//           NUM_REQ valid/ready requesters, with a tagged response channel.
// Rev     : 1.0
// ============================================================================
module nor_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready,
    output logic [CNT_W-1:0]         op_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q,   ptr_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [ID_W-1:0]  id_q,    id_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             slot_open;
    logic             accept;
    logic             complete;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_nor;

    // First pass covers requesters at or above the pointer, second pass wraps
    // to those below it, giving a rotating priority without index arithmetic.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_nor   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
                grant_nor   = ~(req_a[i*WIDTH +: WIDTH] | req_b[i*WIDTH +: WIDTH]);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) < ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
                grant_nor   = ~(req_a[i*WIDTH +: WIDTH] | req_b[i*WIDTH +: WIDTH]);
            end
        end
    end

    assign slot_open = (state_q == IDLE) || rsp_ready;
    assign accept    = slot_open && grant_found && rst_n;
    assign complete  = (state_q == HOLD) && rsp_ready;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        cnt_d   = complete ? cnt_q + CNT_W'(1) : cnt_q;
        if (accept) begin
            state_d = HOLD;
            data_d  = grant_nor;
            id_d    = grant_idx;
            ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (complete) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign op_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nor_share_arbiter.sv
`default_nettype none
// Bench for nor_share_arbiter: a reference arbiter model pushes expected
// responses into a queue at accept time; responses are popped on completion.
module tb_nor_share_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic        rsp_ready;

    wire  [3:0]  req_ready;
    wire         rsp_valid;
    wire  [7:0]  rsp_data;
    wire  [1:0]  rsp_id;
    wire  [15:0] op_count;

    wire  [3:0]  w_req_ready;
    wire         w_rsp_valid;
    wire  [7:0]  w_rsp_data;
    wire  [1:0]  w_rsp_id;
    wire  [3:0]  w_op_count;

    nor_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .op_count(op_count)
    );

    nor_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(w_req_ready), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
        .rsp_id(w_rsp_id), .rsp_ready(rsp_ready), .op_count(w_op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   m_ptr;
    int   m_cnt;
    bit   m_hold;
    int   n_checks;
    int   n_fail;

    function automatic logic [7:0] nor_of(input int i);
        logic [31:0] ta, tb;
        ta = req_a >> (8 * i);
        tb = req_b >> (8 * i);
        return ~(ta[7:0] | tb[7:0]);
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int         idx;
        r = 4'b0000;
        if (rst_n !== 1'b1) return r;
        if (m_hold && !rsp_ready) return r;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_ptr  = 0;
        m_cnt  = 0;
        m_hold = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a = (req_a & ~(32'hFF << (8 * i))) | (32'(a) << (8 * i));
        req_b = (req_b & ~(32'hFF << (8 * i))) | (32'(b) << (8 * i));
    endtask

    // Advance one clock, updating the model with what the edge should do.
    task automatic tick();
        logic [3:0] g;
        bit         comp;
        rsp_t       e;
        g    = exp_ready();
        comp = (rst_n === 1'b1) && m_hold && rsp_ready;
        if (comp) begin
            if (sb.size() > 0) sb.delete(0);
            m_cnt++;
        end
        if (g != 4'b0000) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    e.id   = i;
                    e.data = nor_of(i);
                    sb.push_back(e);
                    m_ptr = (i + 1) % N;
                end
            end
            m_hold = 1'b1;
        end else if (comp) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b0000; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
            n_checks++; if (op_count !== 16'd0 || w_op_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0", op_count, w_op_count); end
            n_checks++; if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_data: got %h/%0d expected 00/0", rsp_data, rsp_id); end
        end
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_forced: got %b expected 0000", req_ready); end
        req_valid = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            n_checks++; if (req_ready !== (4'b0001 << (n % N))) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'b0001 << (n % N)); end
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(n % N) || rsp_data !== 8'hFF) begin
                n_fail++; $display("FAIL rr_rsp%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=ff", n, rsp_valid, rsp_id, rsp_data, n % N);
            end
        end
        req_valid = 4'b0000;
        tick();
        n_checks++; if (op_count !== 16'd5 || w_op_count !== 4'd5) begin n_fail++; $display("FAIL rr_count: got %0d/%0d expected 5", op_count, w_op_count); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_single_op();
        req_valid = 4'b0001; set_op(0, 8'h55, 8'h22); rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h88 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL single_rsp: got v=%b d=%h id=%0d expected v=1 d=88 id=0", rsp_valid, rsp_data, rsp_id);
        end
        tick();
        n_checks++; if (op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", op_count, m_cnt); end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0100; set_op(2, 8'h0F, 8'hF0); rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_accept: got %b expected 0100", req_ready); end
        tick();
        req_valid = 4'b1011; rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_op(2, 8'(c), 8'(c + 1));
            set_op(0, 8'(c), 8'h00);
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0000", c, req_ready); end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_id !== 2'd2) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d expected v=1 d=00 id=2", c, rsp_valid, rsp_data, rsp_id);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_next: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_checks++; if (rsp_id !== 2'd3 || sb.size() == 0 || rsp_data !== sb[0].data) begin
            n_fail++; $display("FAIL bp_rsp3: got id=%0d d=%h expected id=3 d=%h", rsp_id, rsp_data, (sb.size() > 0) ? sb[0].data : 8'hxx);
        end
        tick();
        n_checks++; if (op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", op_count, m_cnt); end
    endtask

    task automatic test_mid_reset();
        req_valid = 4'b0001; set_op(0, 8'h55, 8'h22); rsp_ready = 1'b0;
        #1;
        tick();
        req_valid = 4'b0000;
        #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h88) begin n_fail++; $display("FAIL mr_hold: got v=%b d=%h expected v=1 d=88", rsp_valid, rsp_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL mr_async: got v=%b d=%h id=%0d expected v=0 d=00 id=0", rsp_valid, rsp_data, rsp_id);
        end
        n_checks++; if (op_count !== 16'd0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL mr_clear: got cnt=%0d rdy=%b expected 0/0000", op_count, req_ready); end
        model_reset();
        tick();
        rst_n = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_first_grant: got %b expected 0001", req_ready); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL mr_rsp: got v=%b id=%0d expected v=1 id=0", rsp_valid, rsp_id); end
    endtask

    task automatic test_counter_wrap();
        int c;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        c = 0;
        while (m_cnt < 17 && c < 40) begin
            req_a = $urandom; req_b = $urandom;
            tick();
            c++;
            n_checks++; if (w_op_count !== 4'(m_cnt) || op_count !== 16'(m_cnt)) begin
                n_fail++; $display("FAIL wrap_count: got %0d/%0d expected %0d/%0d", w_op_count, op_count, 4'(m_cnt), m_cnt);
            end
            if (m_cnt == 15) begin
                n_checks++; if (w_op_count !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d expected 15", w_op_count); end
            end
            if (m_cnt == 16) begin
                n_checks++; if (w_op_count !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d expected 0", w_op_count); end
            end
            if (m_cnt == 17) begin
                n_checks++; if (w_op_count !== 4'd1 || op_count !== 16'd17) begin n_fail++; $display("FAIL wrap_1: got %0d/%0d expected 1/17", w_op_count, op_count); end
            end
        end
        n_checks++; if (m_cnt < 17) begin n_fail++; $display("FAIL wrap_timeout: got %0d completions expected 17", m_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 80; c++) begin
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready%0d: got %b expected %b", c, req_ready, exp_ready()); end
            n_checks++; if (rsp_valid !== m_hold) begin n_fail++; $display("FAIL rnd_valid%0d: got %b expected %b", c, rsp_valid, m_hold); end
            if (m_hold && sb.size() > 0) begin
                n_checks++; if (rsp_data !== sb[0].data || rsp_id !== 2'(sb[0].id)) begin
                    n_fail++; $display("FAIL rnd_rsp%0d: got d=%h id=%0d expected d=%h id=%0d", c, rsp_data, rsp_id, sb[0].data, sb[0].id);
                end
            end
            n_checks++; if (op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_count%0d: got %0d expected %0d", c, op_count, m_cnt); end
            tick();
        end
        req_valid = 4'b0000; rsp_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || op_count !== 16'(m_cnt)) begin
            n_fail++; $display("FAIL rnd_drain: got v=%b cnt=%0d expected v=0 cnt=%0d", rsp_valid, op_count, m_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_single_op();
        test_backpressure();
        test_mid_reset();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
